// File: rtl/rst_watchdog_ctrl.sv
// Reset sequencer with staggered per-domain release, followed by run supervision:
// normal halt detection, heartbeat idle watchdog and run-length cap.
module rst_watchdog_ctrl #(
   parameter int NUM_CH       = 1,
   parameter int RST_HOLD     = 25,
   parameter int STAGGER      = 0,
   parameter int IDLE_TIMEOUT = 100000,
   parameter int MAX_CYCLES   = 2000000,
   parameter int CNT_W        = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              halt_in,
   input  logic              hb_in,
   output logic [NUM_CH-1:0] rst_out,
   output logic              running,
   output logic              done,
   output logic              wdt_idle,
   output logic              wdt_cap,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [63:0] CAP_LAST = (MAX_CYCLES > 0) ? 64'(MAX_CYCLES - 1) : 64'd0;

   typedef enum logic [2:0] {S_HOLD, S_RELEASE, S_RUN, S_DONE, S_FAULT} state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [IDX_W-1:0]    rel_idx;
   logic [STG_W-1:0]    stg_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic                idle_trip;
   logic                cap_trip;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A heartbeat only suppresses the idle watchdog; the run-length cap is independent of it.
   assign idle_trip = !hb_in && (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
   assign cap_trip  = (MAX_CYCLES != 0) && (64'(cycle_cnt) == CAP_LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= S_HOLD;
         hold_cnt  <= '0;
         rel_idx   <= '0;
         stg_cnt   <= '0;
         idle_cnt  <= '0;
         cycle_cnt <= '0;
         rst_out   <= '1;
         running   <= 1'b0;
         done      <= 1'b0;
         wdt_idle  <= 1'b0;
         wdt_cap   <= 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state <= S_RELEASE;
               else                                    hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            S_RELEASE: begin
               if (STAGGER == 0) begin
                  rst_out <= '0;
                  state   <= S_RUN;
                  running <= 1'b1;
               end else if (stg_cnt == '0) begin
                  // Domains release lowest index first, so a left shift clears the next bit.
                  rst_out <= rst_out << 1;
                  if (rel_idx == IDX_W'(NUM_CH - 1)) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end else begin
                     rel_idx <= rel_idx + IDX_W'(1);
                     stg_cnt <= STG_W'(STAGGER - 1);
                  end
               end else begin
                  stg_cnt <= stg_cnt - STG_W'(1);
               end
            end
            S_RUN: begin
               cycle_cnt <= sat_inc(cycle_cnt);
               if (halt_in) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  running <= 1'b0;
               end else begin
                  if (hb_in)           idle_cnt <= '0;
                  else if (!idle_trip) idle_cnt <= idle_cnt + IDLE_W'(1);
                  if (idle_trip || cap_trip) begin
                     state   <= S_FAULT;
                     running <= 1'b0;
                     rst_out <= '1;
                  end
                  if (idle_trip) wdt_idle <= 1'b1;
                  if (cap_trip)  wdt_cap  <= 1'b1;
               end
            end
            S_DONE, S_FAULT: ;
            default: state <= S_HOLD;
         endcase
      end
   end

endmodule
